// File: rtl/flag_gen_unit_pkg.sv
// Types shared by the flag generator and the conditional unit: opcodes,
// the default datapath width and the {z,v,n,c} flag vector.
package flag_gen_unit_pkg;

  localparam int WIDTH_DEF = 32;

  // Encodings 3'b110 and 3'b111 decode as MOV as well.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_CMP = 3'b100,
    OP_MOV = 3'b101
  } op_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } flags_t;

endpackage

// File: rtl/flag_alu.sv
// Combinational result and flag compute for the flag generator.
// CMP is evaluated as SUB for flags but reports a zero result.
module flag_alu
  import flag_gen_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] raw;

  assign add_full = {1'b0, a} + {1'b0, b};
  // Carry out of a + ~b + 1 is set exactly when no borrow occurs.
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    raw    = b;
    flags  = '0;
    result = '0;
    case (op)
      OP_ADD: begin
        raw     = add_full[WIDTH-1:0];
        flags.c = add_full[WIDTH];
        flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        raw     = sub_full[WIDTH-1:0];
        flags.c = sub_full[WIDTH];
        flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  raw = a & b;
      OP_ORR:  raw = a | b;
      default: raw = b;
    endcase
    flags.z = (raw == '0);
    flags.n = raw[WIDTH-1];
    result  = (op == OP_CMP) ? '0 : raw;
  end

endmodule

// File: rtl/flag_gen_unit.sv
// Two-stage valid/ready pipeline producing ALU results and flags, with a
// flag-register write strobe and a pending indicator for the conditional unit.
module flag_gen_unit
  import flag_gen_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c,
  output logic             flags_we,
  output logic             flags_pending
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sf;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  flags_t           s2_flags;
  logic             s2_sf;

  logic [1:0]       in_flight;

  logic [WIDTH-1:0] alu_result;
  flags_t           alu_flags;

  logic             in_fire;
  logic             out_fire;
  logic             s1_adv;

  flag_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;
  assign s1_adv   = s1_valid && (!s2_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sf    <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_op    <= op;
        s1_a     <= a;
        s1_b     <= b;
        s1_sf    <= set_flags;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2 holds its contents untouched while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
      s2_sf     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_result <= alu_result;
        s2_flags  <= alu_flags;
        s2_sf     <= s1_sf;
      end else if (out_fire) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= 2'd0;
    end else begin
      case ({in_fire && set_flags, flags_we})
        2'b10:   in_flight <= in_flight + 2'd1;
        2'b01:   in_flight <= in_flight - 2'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign out_valid     = s2_valid;
  assign result        = s2_result;
  assign z             = s2_flags.z;
  assign v             = s2_flags.v;
  assign n             = s2_flags.n;
  assign c             = s2_flags.c;
  assign flags_we      = out_fire && s2_sf;
  assign flags_pending = (in_flight != 2'd0);

endmodule
